zx81_kbd_scheduler: RTL and testbench

Converts PS/2 key events from the ps2 receiver into the ZX81 8x5 keyboard matrix that fpga_zx81 reads during I/O port 0xFE scans. Events are queued in a small FIFO. Each accepted matrix change is held for a minimum time so the ROM's once-per-frame scan sees every press and release, even for fast typing. Sits in clk_sys between ps2 and the core's keyboard input.

---
 rtl/zx81_kbd_scheduler.sv | 235 +++++++++++++++++++++++
 tb/tb_zx81_kbd_scheduler.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zx81_kbd_scheduler.sv
// ----------------------------------------------------------------------------
// zx81_kbd_scheduler
//
// Turns PS/2 key events into the ZX81 8x5 keyboard matrix. Every event is
// queued. A matrix change is then held for HOLD_CYCLES clk_sys cycles before
// the next event is applied. This guarantees that the ROM's once-per-frame
// scan sees every press and every release.
//
// Ports
//   clk_sys    in   system clock
//   reset_n    in   asynchronous active-low reset
//   ps2_key    in   [10] event toggle, [9] pressed, [8] E0-extended,
//                   [7:0] set-2 scancode
//   row_sel_n  in   active-low row select (CPU A8..A15)
//   cols_n     out  active-low column data (combinational)
//   overflow   out  sticky: an event was dropped because the queue was full
//   busy       out  queue non-empty or scheduler not idle
// ----------------------------------------------------------------------------
module zx81_kbd_scheduler #(
   parameter int unsigned DEPTH       = 8,       // power of 2, >= 2
   parameter int unsigned HOLD_CYCLES = 520000   // >= 1, fits in 20 bits
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic [10:0] ps2_key,
   input  logic [7:0]  row_sel_n,
   output logic [4:0]  cols_n,
   output logic        overflow,
   output logic        busy
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned HOLD_W = 20;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_APPLY, S_HOLD} state_t;
   typedef enum logic [2:0] {K_NONE, K_MATRIX, K_LSHIFT, K_RSHIFT, K_BKSP} kind_t;
   typedef struct packed {
      kind_t      kind;
      logic [2:0] row;
      logic [2:0] col;
   } key_dec_t;

   function automatic key_dec_t mk(input logic [2:0] r, input logic [2:0] c);
      mk = '{kind: K_MATRIX, row: r, col: c};
   endfunction

   // Set-2 scancode to matrix position. The SHIFT position (row0 col0) is fed
   // only by the shift and backspace flags, never by a direct key.
   function automatic key_dec_t decode(input logic [7:0] code);
      decode = '{kind: K_NONE, row: 3'd0, col: 3'd0};
      case (code)
         8'h12: decode.kind = K_LSHIFT;
         8'h59: decode.kind = K_RSHIFT;
         8'h66: decode.kind = K_BKSP;
         8'h1A: decode = mk(3'd0, 3'd1);  8'h22: decode = mk(3'd0, 3'd2);
         8'h21: decode = mk(3'd0, 3'd3);  8'h2A: decode = mk(3'd0, 3'd4);
         8'h1C: decode = mk(3'd1, 3'd0);  8'h1B: decode = mk(3'd1, 3'd1);
         8'h23: decode = mk(3'd1, 3'd2);  8'h2B: decode = mk(3'd1, 3'd3);
         8'h34: decode = mk(3'd1, 3'd4);
         8'h15: decode = mk(3'd2, 3'd0);  8'h1D: decode = mk(3'd2, 3'd1);
         8'h24: decode = mk(3'd2, 3'd2);  8'h2D: decode = mk(3'd2, 3'd3);
         8'h2C: decode = mk(3'd2, 3'd4);
         8'h16: decode = mk(3'd3, 3'd0);  8'h1E: decode = mk(3'd3, 3'd1);
         8'h26: decode = mk(3'd3, 3'd2);  8'h25: decode = mk(3'd3, 3'd3);
         8'h2E: decode = mk(3'd3, 3'd4);
         8'h45: decode = mk(3'd4, 3'd0);  8'h46: decode = mk(3'd4, 3'd1);
         8'h3E: decode = mk(3'd4, 3'd2);  8'h3D: decode = mk(3'd4, 3'd3);
         8'h36: decode = mk(3'd4, 3'd4);
         8'h4D: decode = mk(3'd5, 3'd0);  8'h44: decode = mk(3'd5, 3'd1);
         8'h43: decode = mk(3'd5, 3'd2);  8'h3C: decode = mk(3'd5, 3'd3);
         8'h35: decode = mk(3'd5, 3'd4);
         8'h5A: decode = mk(3'd6, 3'd0);  8'h4B: decode = mk(3'd6, 3'd1);
         8'h42: decode = mk(3'd6, 3'd2);  8'h3B: decode = mk(3'd6, 3'd3);
         8'h33: decode = mk(3'd6, 3'd4);
         8'h29: decode = mk(3'd7, 3'd0);  8'h49: decode = mk(3'd7, 3'd1);
         8'h3A: decode = mk(3'd7, 3'd2);  8'h31: decode = mk(3'd7, 3'd3);
         8'h32: decode = mk(3'd7, 3'd4);
         default: ;
      endcase
   endfunction

   // ---------------------------------------------------------------- toggle
   logic       armed_q, prev_tog_q, pend_q;
   logic [9:0] pend_ev_q;

   // The first edge after reset only captures the toggle level. Whatever
   // level ps2_key[10] holds at reset release is therefore not an event.
   // NOTE: sequential state uses non-blocking assignments only; blocking ones
   // here would make the result depend on the order in which blocks evaluate.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         armed_q    <= 1'b0;
         prev_tog_q <= 1'b0;
         pend_q     <= 1'b0;
         pend_ev_q  <= '0;
      end else begin
         armed_q    <= 1'b1;
         prev_tog_q <= ps2_key[10];
         pend_q     <= armed_q && (ps2_key[10] != prev_tog_q);
         if (armed_q && (ps2_key[10] != prev_tog_q)) pend_ev_q <= ps2_key[9:0];
      end
   end

   // ------------------------------------------------------------------ FIFO
   logic [9:0]       mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             overflow_q, fifo_empty, fifo_full, push, pop;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CNT_W'(DEPTH));
   // A pop in the same cycle frees a slot, so a push into a full queue is
   // still accepted.
   assign push = pend_q && (!fifo_full || pop);

   // NOTE: queue storage carries no reset; the pointers and count define which
   // entries are valid, so clearing the array would only add reset fan-out.
   always_ff @(posedge clk_sys) begin
      if (push) mem_q[wr_ptr_q] <= pend_ev_q;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: ;
         endcase
         if (pend_q && !push) overflow_q <= 1'b1;
      end
   end

   // ------------------------------------------------------------- scheduler
   state_t            state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [9:0]        ev_q, ev_d;
   logic [7:0][4:0]   key_q, key_d;
   logic              lshift_q, lshift_d, rshift_q, rshift_d, bksp_q, bksp_d;
   key_dec_t          dec;

   // NOTE: every variable driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      ev_d     = ev_q;
      key_d    = key_q;
      lshift_d = lshift_q;
      rshift_d = rshift_q;
      bksp_d   = bksp_q;
      pop      = 1'b0;
      dec      = decode(ev_q[7:0]);
      unique case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               ev_d    = mem_q[rd_ptr_q];
               state_d = S_APPLY;
            end
         end
         S_APPLY: begin
            // Extended and unmapped codes are consumed without a hold period.
            state_d = S_IDLE;
            if (!ev_q[8] && dec.kind != K_NONE) begin
               state_d = S_HOLD;
               hold_d  = HOLD_LOAD;
               case (dec.kind)
                  K_LSHIFT: lshift_d = ev_q[9];
                  K_RSHIFT: rshift_d = ev_q[9];
                  K_BKSP:   bksp_d   = ev_q[9];
                  K_MATRIX: begin
                     for (int r = 0; r < 8; r++)
                        for (int c = 0; c < 5; c++)
                           if (dec.row == 3'(r) && dec.col == 3'(c)) key_d[r][c] = ev_q[9];
                  end
                  default: ;
               endcase
            end
         end
         S_HOLD: begin
            if (hold_q == '0) state_d = S_IDLE;
            else              hold_d  = hold_q - HOLD_W'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         hold_q   <= '0;
         ev_q     <= '0;
         key_q    <= '0;
         lshift_q <= 1'b0;
         rshift_q <= 1'b0;
         bksp_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         ev_q     <= ev_d;
         key_q    <= key_d;
         lshift_q <= lshift_d;
         rshift_q <= rshift_d;
         bksp_q   <= bksp_d;
      end
   end

   // ---------------------------------------------------------------- matrix
   logic [7:0][4:0] eff;
   logic [4:0]      col_or;

   // Backspace is reported as SHIFT + "0".
   always_comb begin
      eff       = key_q;
      eff[0][0] = key_q[0][0] | lshift_q | rshift_q | bksp_q;
      eff[4][0] = key_q[4][0] | bksp_q;
      col_or    = '0;
      for (int r = 0; r < 8; r++)
         if (!row_sel_n[r]) col_or = col_or | eff[r];
   end

   assign cols_n   = ~col_or;
   assign overflow = overflow_q;
   assign busy     = !fifo_empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_zx81_kbd_scheduler.sv
// ----------------------------------------------------------------------------
// Testbench for zx81_kbd_scheduler (HOLD_CYCLES = 16, DEPTH = 8).
// Table-driven single-key vectors, hand sequences for the timing corners, and
// a queue of expected column patterns for the overflow burst.
// ----------------------------------------------------------------------------
module tb_zx81_kbd_scheduler;

   localparam int HOLD  = 16;
   localparam int DEPTH = 8;

   logic        clk_sys   = 1'b0;
   logic        reset_n   = 1'b0;
   logic [10:0] ps2_key   = '0;
   logic [7:0]  row_sel_n = 8'hFF;
   logic [4:0]  cols_n;
   logic        overflow, busy;

   int   n_vec  = 0;
   int   n_miss = 0;
   logic tog    = 1'b0;
   logic [4:0] sb_q [$];

   zx81_kbd_scheduler #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .ps2_key   (ps2_key),
      .row_sel_n (row_sel_n),
      .cols_n    (cols_n),
      .overflow  (overflow),
      .busy      (busy)
   );

   always #5 clk_sys = ~clk_sys;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic send(input logic pressed, input logic ext, input logic [7:0] code);
      tog     = ~tog;
      ps2_key = {tog, pressed, ext, code};
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      repeat (2) @(negedge clk_sys);
      while (busy && n < 200) begin
         @(negedge clk_sys);
         n++;
      end
      check({name, "_idle"}, 32'(busy), 32'd0);
   endtask

   typedef struct {
      logic [7:0] code;
      logic       ext;
      logic [7:0] sel_n;
      logic [4:0] exp_cols;
      logic       holds;
   } vec_t;

   vec_t       vecs [16];
   logic [7:0] b_code [10];
   logic       b_prs  [10];
   logic [4:0] b_exp  [8];

   initial begin
      int         busy_cnt, on_cnt, cyc, last_t, n_chg, n_extra;
      logic [4:0] last, exp5;

      vecs[0]  = '{8'h1C, 1'b0, 8'hFD, 5'b11110, 1'b1};  // A
      vecs[1]  = '{8'h1A, 1'b0, 8'hFE, 5'b11101, 1'b1};  // Z
      vecs[2]  = '{8'h2A, 1'b0, 8'hFE, 5'b01111, 1'b1};  // V
      vecs[3]  = '{8'h2C, 1'b0, 8'hFB, 5'b01111, 1'b1};  // T
      vecs[4]  = '{8'h2E, 1'b0, 8'hF7, 5'b01111, 1'b1};  // 5
      vecs[5]  = '{8'h45, 1'b0, 8'hEF, 5'b11110, 1'b1};  // 0
      vecs[6]  = '{8'h35, 1'b0, 8'hDF, 5'b01111, 1'b1};  // Y
      vecs[7]  = '{8'h5A, 1'b0, 8'hBF, 5'b11110, 1'b1};  // ENTER
      vecs[8]  = '{8'h33, 1'b0, 8'hBF, 5'b01111, 1'b1};  // H
      vecs[9]  = '{8'h29, 1'b0, 8'h7F, 5'b11110, 1'b1};  // SPACE
      vecs[10] = '{8'h49, 1'b0, 8'h7F, 5'b11101, 1'b1};  // .
      vecs[11] = '{8'h32, 1'b0, 8'h7F, 5'b01111, 1'b1};  // B
      vecs[12] = '{8'h12, 1'b0, 8'hFE, 5'b11110, 1'b1};  // left shift
      vecs[13] = '{8'h59, 1'b0, 8'hFE, 5'b11110, 1'b1};  // right shift
      vecs[14] = '{8'h1C, 1'b1, 8'hFD, 5'b11111, 1'b0};  // E0 1C: extended
      vecs[15] = '{8'h76, 1'b0, 8'h00, 5'b11111, 1'b0};  // ESC: unmapped

      // Burst while Q is held: W E R T down, T R E W up, then E and R down
      // (the last two find the queue full).
      b_code = '{8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h2C, 8'h2D, 8'h24, 8'h1D, 8'h24, 8'h2D};
      b_prs  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      b_exp  = '{5'b11100, 5'b11000, 5'b10000, 5'b00000,
                 5'b10000, 5'b11000, 5'b11100, 5'b11110};

      // ---- reset state
      row_sel_n = 8'h00;
      repeat (3) @(negedge clk_sys);
      check("rst_cols", 32'(cols_n), 32'h1F);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk_sys);
      check("armed_no_event", 32'(busy), 32'd0);

      // ---- A: latency and busy duration (HOLD + queue + APPLY = 18 cycles)
      row_sel_n = 8'hFD;
      send(1'b1, 1'b0, 8'h1C);
      busy_cnt = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk_sys);
         if (busy) busy_cnt++;
         if (i == 3) check("a_not_yet", 32'(cols_n), 32'h1F);
         if (i == 4) check("a_valid", 32'(cols_n), 32'h1E);
      end
      check("a_busy_cycles", 32'(busy_cnt), 32'(HOLD + 2));
      send(1'b0, 1'b0, 8'h1C);
      wait_idle("a_rel");
      check("a_released", 32'(cols_n), 32'h1F);

      // ---- table of single keys
      for (int i = 0; i < 16; i++) begin
         row_sel_n = vecs[i].sel_n;
         send(1'b1, vecs[i].ext, vecs[i].code);
         repeat (4) @(negedge clk_sys);
         check($sformatf("vec%0d_cols", i), 32'(cols_n), 32'(vecs[i].exp_cols));
         check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].holds));
         row_sel_n = ~vecs[i].sel_n;
         #1;
         check($sformatf("vec%0d_other_rows", i), 32'(cols_n), 32'h1F);
         send(1'b0, vecs[i].ext, vecs[i].code);
         wait_idle($sformatf("vec%0d", i));
         row_sel_n = vecs[i].sel_n;
         #1;
         check($sformatf("vec%0d_released", i), 32'(cols_n), 32'h1F);
      end

      // ---- press and release on consecutive cycles: nothing is lost. The
      // release waits out the full hold, then its own IDLE and APPLY cycles.
      @(negedge clk_sys);
      row_sel_n = 8'hFD;
      send(1'b1, 1'b0, 8'h1C);
      @(negedge clk_sys);
      send(1'b0, 1'b0, 8'h1C);
      on_cnt = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk_sys);
         if (cols_n[0] == 1'b0) on_cnt++;
      end
      check("pulse_len", 32'(on_cnt), 32'(HOLD + 2));
      check("pulse_end", 32'(cols_n), 32'h1F);

      // ---- backspace = SHIFT + 0, independent of lshift
      row_sel_n = 8'hFE;
      send(1'b1, 1'b0, 8'h66);
      repeat (4) @(negedge clk_sys);
      check("bksp_shift", 32'(cols_n), 32'h1E);
      row_sel_n = 8'hEF;
      #1;
      check("bksp_zero", 32'(cols_n), 32'h1E);
      wait_idle("bksp");
      send(1'b1, 1'b0, 8'h12);
      wait_idle("lshift");
      send(1'b0, 1'b0, 8'h66);
      wait_idle("bksp_rel");
      check("bksp_rel_zero", 32'(cols_n), 32'h1F);
      row_sel_n = 8'hFE;
      #1;
      check("bksp_rel_lshift_kept", 32'(cols_n), 32'h1E);
      send(1'b0, 1'b0, 8'h12);
      wait_idle("lshift_rel");
      check("lshift_released", 32'(cols_n), 32'h1F);

      // ---- two rows at once, then an extended code that must be ignored
      row_sel_n = 8'h00;
      send(1'b1, 1'b0, 8'h1A);
      @(negedge clk_sys);
      send(1'b1, 1'b0, 8'h15);
      wait_idle("zq");
      check("zq_all_rows", 32'(cols_n), 32'h1C);
      send(1'b1, 1'b1, 8'h75);
      repeat (4) @(negedge clk_sys);
      check("ext_no_change", 32'(cols_n), 32'h1C);
      check("ext_no_hold", 32'(busy), 32'd0);
      send(1'b0, 1'b0, 8'h1A);
      @(negedge clk_sys);
      send(1'b0, 1'b0, 8'h15);
      wait_idle("zq_rel");
      check("zq_released", 32'(cols_n), 32'h1F);

      // ---- burst of 10 during one hold: 8 queued, 2 dropped, overflow set
      check("ovf_before_burst", 32'(overflow), 32'd0);
      row_sel_n = 8'hFB;
      send(1'b1, 1'b0, 8'h15);
      repeat (4) @(negedge clk_sys);
      check("burst_q_held", 32'(cols_n), 32'h1E);
      for (int j = 0; j < 10; j++) begin
         send(b_prs[j], 1'b0, b_code[j]);
         if (j < DEPTH) sb_q.push_back(b_exp[j]);
         @(negedge clk_sys);
      end
      last   = cols_n;
      cyc    = 0;
      last_t = 0;
      n_chg  = 0;
      while (sb_q.size() > 0 && cyc < 400) begin
         @(negedge clk_sys);
         cyc++;
         if (cols_n !== last) begin
            exp5 = sb_q.pop_front();
            check($sformatf("burst%0d_cols", n_chg), 32'(cols_n), 32'(exp5));
            if (n_chg > 0) check($sformatf("burst%0d_gap", n_chg), 32'(cyc - last_t), 32'(HOLD + 2));
            last_t = cyc;
            last   = cols_n;
            n_chg++;
         end
      end
      check("burst_drained", 32'(sb_q.size()), 32'd0);
      n_extra = 0;
      repeat (60) begin
         @(negedge clk_sys);
         if (cols_n !== last) begin
            n_extra++;
            last = cols_n;
         end
      end
      check("burst_no_extra", 32'(n_extra), 32'd0);
      check("burst_overflow", 32'(overflow), 32'd1);
      send(1'b0, 1'b0, 8'h15);
      wait_idle("burst_q_rel");
      check("burst_q_released", 32'(cols_n), 32'h1F);
      check("ovf_sticky", 32'(overflow), 32'd1);

      // ---- async reset mid-hold with the toggle line high
      row_sel_n = 8'hFE;
      if (tog == 1'b1) begin
         send(1'b1, 1'b0, 8'h76);
         wait_idle("pre_rst");
      end
      send(1'b1, 1'b0, 8'h22);  // X; toggle line is now 1
      repeat (8) @(negedge clk_sys);
      check("rst_x_held", 32'(cols_n), 32'h1B);
      check("rst_mid_hold_busy", 32'(busy), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      row_sel_n = 8'h00;
      #1;
      check("rst2_cols", 32'(cols_n), 32'h1F);
      check("rst2_overflow", 32'(overflow), 32'd0);
      check("rst2_busy", 32'(busy), 32'd0);
      @(negedge clk_sys);
      reset_n  = 1'b1;
      busy_cnt = 0;
      repeat (12) begin
         @(negedge clk_sys);
         if (busy) busy_cnt++;
      end
      check("rst2_no_spurious", 32'(busy_cnt), 32'd0);
      check("rst2_cols_after", 32'(cols_n), 32'h1F);
      send(1'b1, 1'b0, 8'h21);  // C, toggle 1 -> 0
      repeat (4) @(negedge clk_sys);
      check("rst2_next_event", 32'(cols_n), 32'h17);
      send(1'b0, 1'b0, 8'h21);
      wait_idle("rst2_c_rel");
      check("rst2_c_released", 32'(cols_n), 32'h1F);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
